// File: rtl/life_grid_engine_if.sv
// Control, rule and readout bundle for life_grid_engine.
// The seed-loading side drives through master; the engine attaches as slave.
interface life_grid_engine_if #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) ();
  logic [ROWS*COLS-1:0] seeds;
  logic                 load;
  logic                 run;
  logic                 step;
  logic [8:0]           birth_mask;
  logic [8:0]           survive_mask;
  logic [ROWS*COLS-1:0] cells;
  logic [GEN_W-1:0]     gen_count;
  logic                 gen_tick;
  logic                 stable;
  logic                 extinct;
  logic [1:0]           state;

  modport master (
    output seeds, load, run, step, birth_mask, survive_mask,
    input  cells, gen_count, gen_tick, stable, extinct, state
  );

  modport slave (
    input  seeds, load, run, step, birth_mask, survive_mask,
    output cells, gen_count, gen_tick, stable, extinct, state
  );
endinterface

// File: rtl/life_grid_engine.sv
// Register-held cellular automaton with run-time rule masks, run/pause/step control,
// a saturating generation counter and automatic halt on stable or extinct states.
module life_grid_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16
) (
  input  logic clk,
  input  logic rst,
  life_grid_engine_if.slave bus
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAUSED  = 2'd1,
    ST_RUNNING = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     cells_q, cells_d, next_s;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             tick_q, tick_d;
  logic             stable_q, stable_d;
  logic             commit_s, halt_s;

  // Whole-array next generation; off-grid neighbours read as dead unless wrapping.
  function automatic logic [N-1:0] next_gen(input logic [N-1:0] g,
                                            input logic [8:0] bm,
                                            input logic [8:0] sm);
    logic [N-1:0]     n;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] idx;
    int               rr, cc;
    n = {N{1'b0}};
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cnt = 4'd0;
        for (int dr = 0; dr < 3; dr++) begin
          for (int dc = 0; dc < 3; dc++) begin
            if (!(dr == 1 && dc == 1)) begin
              if (WRAP != 0) begin
                rr  = (r + dr + ROWS - 1) % ROWS;
                cc  = (c + dc + COLS - 1) % COLS;
                idx = IDX_W'(rr * COLS + cc);
                cnt = cnt + {3'd0, g[idx]};
              end else begin
                rr = r + dr - 1;
                cc = c + dc - 1;
                if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                  idx = IDX_W'(rr * COLS + cc);
                  cnt = cnt + {3'd0, g[idx]};
                end
              end
            end
          end
        end
        idx    = IDX_W'(r * COLS + c);
        n[idx] = g[idx] ? sm[cnt] : bm[cnt];
      end
    end
    return n;
  endfunction

  // Candidate generation and halt test on the result that would be committed.
  always_comb begin
    next_s = next_gen(cells_q, bus.birth_mask, bus.survive_mask);
    halt_s = (next_s == cells_q) || (next_s == {N{1'b0}});
  end

  // Control FSM: load overrides everything; step wins over run while paused.
  always_comb begin
    state_d  = state_q;
    commit_s = 1'b0;
    if (bus.load) begin
      state_d = ST_PAUSED;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_PAUSED: begin
          if (bus.step) begin
            commit_s = 1'b1;
            state_d  = halt_s ? ST_HALTED : (bus.run ? ST_RUNNING : ST_PAUSED);
          end else if (bus.run) begin
            state_d = ST_RUNNING;
          end else begin
            state_d = ST_PAUSED;
          end
        end
        ST_RUNNING: begin
          if (bus.run) begin
            commit_s = 1'b1;
            state_d  = halt_s ? ST_HALTED : ST_RUNNING;
          end else begin
            state_d = ST_PAUSED;
          end
        end
        ST_HALTED:  state_d = ST_HALTED;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath updates for load and commit; gen_tick is a one-cycle pulse.
  always_comb begin
    cells_d  = cells_q;
    gen_d    = gen_q;
    tick_d   = 1'b0;
    stable_d = stable_q;
    if (bus.load) begin
      cells_d  = bus.seeds;
      gen_d    = {GEN_W{1'b0}};
      stable_d = 1'b0;
    end else if (commit_s) begin
      cells_d  = next_s;
      gen_d    = (gen_q == {GEN_W{1'b1}}) ? gen_q : gen_q + GEN_W'(1);
      tick_d   = 1'b1;
      stable_d = (next_s == cells_q);
    end else begin
      cells_d = cells_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cells_q  <= {N{1'b0}};
      gen_q    <= {GEN_W{1'b0}};
      tick_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cells_q  <= cells_d;
      gen_q    <= gen_d;
      tick_q   <= tick_d;
      stable_q <= stable_d;
    end
  end

  assign bus.cells     = cells_q;
  assign bus.gen_count = gen_q;
  assign bus.gen_tick  = tick_q;
  assign bus.stable    = stable_q;
  assign bus.extinct   = ~|cells_q;
  assign bus.state     = state_q;
endmodule
